// File: rtl/eeg_oram_pkg.sv
// Shared types for the ORAM bank drain controller.
package eeg_oram_pkg;

  localparam int unsigned ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StFlush = 2'd2,
    StFin   = 2'd3
  } oram_state_e;

endpackage

// File: rtl/eeg_oram_next_port.sv
// Port-walk helper: lowest set mask bit, next set bit above cur, and whether any remain above cur.
module eeg_oram_next_port #(
  parameter int unsigned  NumPorts = 4,
  localparam int unsigned PW       = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic [NumPorts-1:0] mask_i,
  input  logic [PW-1:0]       cur_i,
  output logic [PW-1:0]       next_o,
  output logic [PW-1:0]       first_o,
  output logic                none_left_o
);

  // Scan downwards so the last hit is the lowest qualifying bit.
  always_comb begin
    first_o     = '0;
    next_o      = '0;
    none_left_o = 1'b1;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        first_o = PW'(i);
        if (i > int'(cur_i)) begin
          next_o      = PW'(i);
          none_left_o = 1'b0;
        end
      end
    end
    if (none_left_o) next_o = first_o;
  end

endmodule

// File: rtl/eeg_oram_drain_ctrl.sv
// Readout sequencer for one ORAM bank: walks enabled OMUX ports, issues reads 0..LEN-1 per port
// and merges the returned words into a single tagged valid/ready stream.
module eeg_oram_drain_ctrl
  import eeg_oram_pkg::*;
#(
  parameter int unsigned  OMUX_NUM_DW = 4,
  parameter int unsigned  OMUX_ADD_AW = 8,
  parameter int unsigned  ORAM_DAT_DW = 8,
  localparam int unsigned PW          = (OMUX_NUM_DW > 1) ? $clog2(OMUX_NUM_DW) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               START,
  input  logic [OMUX_ADD_AW:0]               CFG_LEN,
  input  logic [OMUX_NUM_DW-1:0]             CFG_MASK,
  output logic                               BUSY,
  output logic                               DONE,
  output logic [OMUX_NUM_DW-1:0]             ORAM_ADD_VLD,
  output logic [OMUX_NUM_DW-1:0]             ORAM_ADD_LST,
  input  logic [OMUX_NUM_DW-1:0]             ORAM_ADD_RDY,
  output logic [OMUX_NUM_DW*OMUX_ADD_AW-1:0] ORAM_ADD_ADD,
  input  logic [OMUX_NUM_DW-1:0]             ORAM_DAT_VLD,
  input  logic [OMUX_NUM_DW-1:0]             ORAM_DAT_LST,
  output logic [OMUX_NUM_DW-1:0]             ORAM_DAT_RDY,
  input  logic [OMUX_NUM_DW*ORAM_DAT_DW-1:0] ORAM_DAT_DAT,
  output logic                               OUT_VLD,
  input  logic                               OUT_RDY,
  output logic [ORAM_DAT_DW-1:0]             OUT_DAT,
  output logic [PW-1:0]                      OUT_PRT,
  output logic                               OUT_LST
);

  localparam int unsigned CW = OMUX_ADD_AW + 1;

  oram_state_e            state_q, state_d;
  logic [PW-1:0]          sel_q, sel_d;
  logic [CW-1:0]          addr_q, addr_d;
  logic [CW-1:0]          len_q, len_d;
  logic [OMUX_NUM_DW-1:0] mask_q, mask_d;

  logic [OMUX_NUM_DW-1:0] np_mask;
  logic [PW-1:0]          np_next, np_first;
  logic                   np_none_left;
  logic                   add_lst, add_acc, out_hs;

  // In IDLE the walker looks at the live config so the first port is known at START.
  assign np_mask = (state_q == StIdle) ? CFG_MASK : mask_q;

  eeg_oram_next_port #(
    .NumPorts (OMUX_NUM_DW)
  ) u_next_port (
    .mask_i      (np_mask),
    .cur_i       (sel_q),
    .next_o      (np_next),
    .first_o     (np_first),
    .none_left_o (np_none_left)
  );

  assign BUSY    = (state_q != StIdle);
  assign DONE    = (state_q == StFin);
  assign add_lst = (addr_q == len_q - CW'(1));
  assign add_acc = (state_q == StIssue) && ORAM_ADD_RDY[sel_q];
  assign OUT_VLD = ORAM_DAT_VLD[sel_q] & BUSY;
  assign out_hs  = OUT_VLD & OUT_RDY;
  assign OUT_DAT = ORAM_DAT_DAT[int'(sel_q)*ORAM_DAT_DW +: ORAM_DAT_DW];
  assign OUT_PRT = sel_q;
  assign OUT_LST = ORAM_DAT_LST[sel_q] & np_none_left & BUSY;

  always_comb begin
    ORAM_ADD_VLD = '0;
    ORAM_ADD_LST = '0;
    ORAM_DAT_RDY = '1;
    if (state_q == StIssue) begin
      ORAM_ADD_VLD[sel_q] = 1'b1;
      ORAM_ADD_LST[sel_q] = add_lst;
    end
    // Only the selected lane is backpressured; idle lanes never hold a word.
    if (BUSY) ORAM_DAT_RDY[sel_q] = OUT_RDY;
  end

  always_comb begin
    for (int i = 0; i < int'(OMUX_NUM_DW); i++) begin
      ORAM_ADD_ADD[i*OMUX_ADD_AW +: OMUX_ADD_AW] = addr_q[OMUX_ADD_AW-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    len_d   = len_q;
    mask_d  = mask_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          len_d  = CFG_LEN;
          mask_d = CFG_MASK;
          addr_d = '0;
          if (CFG_LEN == '0 || CFG_MASK == '0) begin
            state_d = StFin;
          end else begin
            sel_d   = np_first;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (add_acc) begin
          if (add_lst) begin
            // Wrap only here so LEN = 2^AW still reaches the full address range.
            addr_d  = '0;
            state_d = StFlush;
          end else begin
            addr_d = addr_q + CW'(1);
          end
        end
      end
      StFlush: begin
        if (out_hs && ORAM_DAT_LST[sel_q]) begin
          if (np_none_left) begin
            state_d = StFin;
          end else begin
            sel_d   = np_next;
            addr_d  = '0;
            state_d = StIssue;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sel_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      mask_q  <= mask_d;
    end
  end

endmodule

// File: tb/tb_eeg_oram_drain_ctrl.sv
// Directed bench for eeg_oram_drain_ctrl with a one-deep registered bank model per lane.
module tb_eeg_oram_drain_ctrl;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int PW = 2;

  logic            clk      = 1'b0;
  logic            rst_n    = 1'b1;
  logic            START    = 1'b0;
  logic [AW:0]     CFG_LEN  = '0;
  logic [N-1:0]    CFG_MASK = '0;
  logic            BUSY, DONE;
  logic [N-1:0]    ORAM_ADD_VLD, ORAM_ADD_LST, ORAM_ADD_RDY;
  logic [N*AW-1:0] ORAM_ADD_ADD;
  logic [N-1:0]    ORAM_DAT_VLD, ORAM_DAT_LST, ORAM_DAT_RDY;
  logic [N*DW-1:0] ORAM_DAT_DAT;
  logic            OUT_VLD;
  logic            OUT_RDY  = 1'b1;
  logic [DW-1:0]   OUT_DAT;
  logic [PW-1:0]   OUT_PRT;
  logic            OUT_LST;
  logic            wr_block = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  eeg_oram_drain_ctrl #(
    .OMUX_NUM_DW (N),
    .OMUX_ADD_AW (AW),
    .ORAM_DAT_DW (DW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .START        (START),
    .CFG_LEN      (CFG_LEN),
    .CFG_MASK     (CFG_MASK),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .ORAM_ADD_VLD (ORAM_ADD_VLD),
    .ORAM_ADD_LST (ORAM_ADD_LST),
    .ORAM_ADD_RDY (ORAM_ADD_RDY),
    .ORAM_ADD_ADD (ORAM_ADD_ADD),
    .ORAM_DAT_VLD (ORAM_DAT_VLD),
    .ORAM_DAT_LST (ORAM_DAT_LST),
    .ORAM_DAT_RDY (ORAM_DAT_RDY),
    .ORAM_DAT_DAT (ORAM_DAT_DAT),
    .OUT_VLD      (OUT_VLD),
    .OUT_RDY      (OUT_RDY),
    .OUT_DAT      (OUT_DAT),
    .OUT_PRT      (OUT_PRT),
    .OUT_LST      (OUT_LST)
  );

  // Bank: refuses addresses during a write burst or while its output word is unconsumed.
  assign ORAM_ADD_RDY = {N{~wr_block}} & (~ORAM_DAT_VLD | ORAM_DAT_RDY);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ORAM_DAT_VLD <= '0;
      ORAM_DAT_LST <= '0;
      ORAM_DAT_DAT <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ORAM_ADD_VLD[i] && ORAM_ADD_RDY[i]) begin
          ORAM_DAT_VLD[i]           <= 1'b1;
          ORAM_DAT_LST[i]           <= ORAM_ADD_LST[i];
          ORAM_DAT_DAT[i*DW +: DW]  <= ORAM_ADD_ADD[i*AW +: AW] + 8'(64 * i);
        end else if (ORAM_DAT_RDY[i]) begin
          ORAM_DAT_VLD[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(BUSY), 0);
    chk({tag, "_done"}, 32'(DONE), 0);
    chk({tag, "_add_vld"}, 32'(ORAM_ADD_VLD), 0);
    chk({tag, "_add_lst"}, 32'(ORAM_ADD_LST), 0);
    chk({tag, "_add_add"}, ORAM_ADD_ADD, 0);
    chk({tag, "_out_vld"}, 32'(OUT_VLD), 0);
    chk({tag, "_out_prt"}, 32'(OUT_PRT), 0);
    chk({tag, "_dat_rdy"}, 32'(ORAM_DAT_RDY), 32'hF);
  endtask

  // One START..DONE job; stall_at > 0 holds ADD_RDY low for 5 cycles from that cycle,
  // poke re-pulses START with other config while busy.
  task automatic run_job(input string tg, input logic [AW:0] len, input logic [N-1:0] mask,
                         input bit rnd, input int stall_at, input bit poke);
    int ep[$];
    int ea[$];
    int n, got, iss, cyc, first_cyc, last_cyc, done_cyc, bad_lane, budget, lane;
    logic [N-1:0]    s_vld, s_lst;
    logic [N*AW-1:0] s_add;
    for (int p = 0; p < N; p++) begin
      if (mask[p]) begin
        for (int a = 0; a < int'(len); a++) begin
          ep.push_back(p);
          ea.push_back(a);
        end
      end
    end
    n = ep.size();
    got = 0; iss = 0; cyc = 0; bad_lane = 0; lane = 0;
    first_cyc = -1; last_cyc = -1; done_cyc = -1;
    s_vld = '0; s_lst = '0; s_add = '0;
    budget = 6 * n + 40;
    @(negedge clk);
    CFG_LEN = len; CFG_MASK = mask; START = 1'b1; OUT_RDY = 1'b1;
    while (done_cyc < 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      START    = poke && (cyc == 4);
      CFG_LEN  = (poke && cyc == 4) ? 9'd2 : 9'd1;
      CFG_MASK = ~mask;
      OUT_RDY  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_block = (stall_at > 0) && (cyc >= stall_at) && (cyc < stall_at + 5);
      #1;
      if (cyc == 1) chk({tg, "_busy"}, 32'(BUSY), 1);
      if (wr_block) begin
        if (cyc == stall_at) begin
          s_vld = ORAM_ADD_VLD; s_lst = ORAM_ADD_LST; s_add = ORAM_ADD_ADD;
          chk({tg, "_stall_in_issue"}, 32'(|s_vld), 1);
        end else begin
          chk({tg, "_hold_vld"}, 32'(ORAM_ADD_VLD), 32'(s_vld));
          chk({tg, "_hold_lst"}, 32'(ORAM_ADD_LST), 32'(s_lst));
          chk({tg, "_hold_add"}, ORAM_ADD_ADD, s_add);
        end
      end
      if ((ORAM_ADD_VLD & ~mask) != '0 || $countones(ORAM_ADD_VLD) > 1) bad_lane++;
      if (|(ORAM_ADD_VLD & ORAM_ADD_RDY)) begin
        for (int i = 0; i < N; i++) if (ORAM_ADD_VLD[i] && ORAM_ADD_RDY[i]) lane = i;
        if (iss < n) begin
          chk({tg, "_iss_prt"}, lane, ep[iss]);
          chk({tg, "_iss_add"}, 32'(ORAM_ADD_ADD[lane*AW +: AW]), ea[iss] & 255);
          chk({tg, "_iss_lst"}, 32'(ORAM_ADD_LST[lane]), 32'(ea[iss] == int'(len) - 1));
        end else begin
          chk({tg, "_iss_extra"}, iss, n);
        end
        iss++;
      end
      if (OUT_VLD && first_cyc < 0) first_cyc = cyc;
      if (OUT_VLD && OUT_RDY) begin
        if (got < n) begin
          chk({tg, "_out_prt"}, 32'(OUT_PRT), ep[got]);
          chk({tg, "_out_dat"}, 32'(OUT_DAT), (ea[got] + 64 * ep[got]) & 255);
          chk({tg, "_out_lst"}, 32'(OUT_LST), 32'(got == n - 1));
        end else begin
          chk({tg, "_out_extra"}, got, n);
        end
        got++;
        last_cyc = cyc;
      end
      if (DONE) done_cyc = cyc;
    end
    wr_block = 1'b0;
    chk({tg, "_done_seen"}, 32'(done_cyc >= 0), 1);
    chk({tg, "_words"}, got, n);
    chk({tg, "_issues"}, iss, n);
    chk({tg, "_bad_lane"}, bad_lane, 0);
    if (n > 0) begin
      chk({tg, "_first_lat"}, first_cyc, 2);
      chk({tg, "_done_lat"}, done_cyc, last_cyc + 1);
    end else begin
      chk({tg, "_done_lat0"}, done_cyc, 1);
    end
    @(negedge clk);
    START = 1'b0;
    #1;
    chk({tg, "_done_pulse"}, 32'(DONE), 0);
    chk({tg, "_idle_busy"}, 32'(BUSY), 0);
  endtask

  initial begin
    bit hit;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    run_job("t1", 9'd4, 4'b1111, 1'b0, 0, 1'b0);
    run_job("t2", 9'd3, 4'b1010, 1'b0, 0, 1'b1);
    run_job("t3", 9'd8, 4'b1111, 1'b1, 0, 1'b0);
    run_job("t4", 9'd8, 4'b0110, 1'b0, 4, 1'b0);
    run_job("t5_len0", 9'd0, 4'b1111, 1'b0, 0, 1'b0);
    run_job("t5_mask0", 9'd5, 4'b0000, 1'b0, 0, 1'b0);
    run_job("t5_len256", 9'd256, 4'b0001, 1'b0, 0, 1'b0);

    // Reset in ISSUE at port 0, address 5.
    @(negedge clk);
    CFG_LEN = 9'd8; CFG_MASK = 4'b1111; START = 1'b1; OUT_RDY = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      START = 1'b0;
      #1;
      if (ORAM_ADD_VLD[0] && ORAM_ADD_ADD[AW-1:0] == 8'd5) hit = 1'b1;
    end
    chk("t6_reach", 32'(hit), 1);
    rst_n = 1'b0;
    #1 chk_reset_outputs("t6_rst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk("t6_nodone_in_rst", 32'(DONE), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("t6_nodone_after", 32'(DONE), 0);
      chk("t6_idle_after", 32'(BUSY), 0);
    end
    run_job("t6_clean", 9'd8, 4'b1111, 1'b0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
